refill_victim_sel: RTL

- Replacement stage that sits directly downstream of the cache's 8-bit LFSR way generator.
- Tracks per-set way-valid bits for a set-associative cache. On each miss it picks the victim way: the lowest-index invalid way, otherwise the LFSR's one-hot way.
- Advances the LFSR only when a random victim was actually consumed.
- Issues the refill request with a valid/ready handshake, marks the way valid on completion, and supports a full flush.

---
 rtl/refill_victim_sel.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/refill_victim_sel.sv
// rtl/refill_victim_sel.sv - refill victim selection with per-set way-valid tracking (optional VICTIM_RAND_STATS_EN)
module refill_victim_sel #(
   parameter int NB_WAYS = 8,
   parameter int NB_SETS = 16,
   localparam int SET_W = $clog2(NB_SETS),
   localparam int WAY_W = $clog2(NB_WAYS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [SET_W-1:0]   req_set_i,
   input  logic [NB_WAYS-1:0] lfsr_way_oh_i,
   output logic               lfsr_en_o,
   output logic               refill_valid_o,
   input  logic               refill_ready_i,
   output logic [SET_W-1:0]   refill_set_o,
   output logic [NB_WAYS-1:0] refill_way_oh_o,
   output logic [WAY_W-1:0]   refill_way_bin_o,
   input  logic [SET_W-1:0]   lookup_set_i,
   output logic [NB_WAYS-1:0] lookup_valid_o,
   input  logic               flush_req_i,
   output logic               flush_ack_o,
   output logic [15:0]        rand_evict_cnt_o
);

   typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_e;

   state_e state_q, state_d;

   logic [NB_SETS-1:0][NB_WAYS-1:0] valid_q;
   logic [NB_WAYS-1:0] cur_valid;
   logic               all_valid;
   logic [NB_WAYS-1:0] free_oh;
   logic               free_found;
   logic [NB_WAYS-1:0] victim_oh;
   logic [WAY_W-1:0]   victim_bin;
   logic               accept;
   logic               refill_done;

   assign lookup_valid_o = valid_q[lookup_set_i];

   // Victim choice: first free way of the requested set, else the LFSR way; binary is its lowest set bit.
   always_comb begin
      cur_valid  = valid_q[req_set_i];
      all_valid  = &cur_valid;
      free_oh    = '0;
      free_found = 1'b0;
      for (int i = 0; i < NB_WAYS; i++) begin
         if (!free_found && !cur_valid[i]) begin
            free_oh[i] = 1'b1;
            free_found = 1'b1;
         end
      end
      victim_oh  = all_valid ? lfsr_way_oh_i : free_oh;
      victim_bin = '0;
      for (int i = NB_WAYS - 1; i >= 0; i--) begin
         if (victim_oh[i]) begin
            victim_bin = WAY_W'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; a pending flush blocks new requests in IDLE.
   always_comb begin
      state_d        = state_q;
      req_ready_o    = 1'b0;
      accept         = 1'b0;
      lfsr_en_o      = 1'b0;
      refill_valid_o = 1'b0;
      refill_done    = 1'b0;
      flush_ack_o    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = !flush_req_i;
            if (flush_req_i) begin
               state_d = FLUSH;
            end else if (req_valid_i) begin
               accept    = 1'b1;
               lfsr_en_o = all_valid;
               state_d   = REFILL;
            end
         end
         REFILL: begin
            refill_valid_o = 1'b1;
            if (refill_ready_i) begin
               refill_done = 1'b1;
               state_d     = IDLE;
            end
         end
         FLUSH: begin
            flush_ack_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the refill target at acceptance; it stays frozen for the whole handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         refill_set_o     <= '0;
         refill_way_oh_o  <= '0;
         refill_way_bin_o <= '0;
      end else if (accept) begin
         refill_set_o     <= req_set_i;
         refill_way_oh_o  <= victim_oh;
         refill_way_bin_o <= victim_bin;
      end
   end

   // Way-valid array: flush clears everything, a completed refill marks its way.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (flush_ack_o) begin
         valid_q <= '0;
      end else if (refill_done) begin
         valid_q[refill_set_o] <= valid_q[refill_set_o] | refill_way_oh_o;
      end
   end

`ifdef VICTIM_RAND_STATS_EN
   logic [15:0] rand_cnt_q;

   // Saturating count of random evictions; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rand_cnt_q <= '0;
      end else if (lfsr_en_o && (rand_cnt_q != 16'hFFFF)) begin
         rand_cnt_q <= rand_cnt_q + 16'd1;
      end
   end

   assign rand_evict_cnt_o = rand_cnt_q;
`else
   assign rand_evict_cnt_o = 16'h0000;
`endif

endmodule
